// File: rtl/apb_chk_pkg21.sv
// Shared definitions for the APB protocol checker: bus phase encoding and
// the bit positions of the sticky error vector.
package apb_chk_pkg21;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  localparam int unsigned ERR_W = 10;

  localparam logic [3:0] ERR_PADDR    = 4'd0;
  localparam logic [3:0] ERR_PRWD     = 4'd1;
  localparam logic [3:0] ERR_PWDATA   = 4'd2;
  localparam logic [3:0] ERR_PENABLE  = 4'd3;
  localparam logic [3:0] ERR_PSEL     = 4'd4;
  localparam logic [3:0] ERR_PSLVERR  = 4'd5;
  localparam logic [3:0] ERR_PRDATA   = 4'd6;
  localparam logic [3:0] ERR_MULTISEL = 4'd7;
  localparam logic [3:0] ERR_PROTOCOL = 4'd8;
  localparam logic [3:0] ERR_TIMEOUT  = 4'd9;

endpackage

// File: rtl/apb_sat_cnt21.sv
// Saturating up-counter with synchronous clear; clear takes priority over increment.
module apb_sat_cnt21 #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/apb_protocol_checker21.sv
// Passive APB checker: tracks IDLE/SETUP/ACCESS, flags X/Z and sequencing
// errors into a sticky vector, and keeps transfer statistics.
module apb_protocol_checker21
  import apb_chk_pkg21::*;
#(
  parameter int unsigned PADDR_WIDTH21    = 32,
  parameter int unsigned PWDATA_WIDTH21   = 32,
  parameter int unsigned PRDATA_WIDTH21   = 32,
  parameter int unsigned NUM_SLAVES21     = 16,
  parameter int unsigned TIMEOUT_CYCLES21 = 256,
  parameter int unsigned CNT_WIDTH21      = 16
) (
  input  logic                      pclock21,
  input  logic                      preset21,
  input  logic                      has_checks21,
  input  logic [PADDR_WIDTH21-1:0]  paddr21,
  input  logic                      prwd21,
  input  logic [PWDATA_WIDTH21-1:0] pwdata21,
  input  logic                      penable21,
  input  logic [NUM_SLAVES21-1:0]   psel21,
  input  logic [PRDATA_WIDTH21-1:0] prdata21,
  input  logic                      pslverr21,
  input  logic                      pready21,
  input  logic                      err_clear21,
  output logic [ERR_W-1:0]          err_vec21,
  output logic                      err_pulse21,
  output logic                      xfer_done21,
  output logic [CNT_WIDTH21-1:0]    xfer_cnt21,
  output logic [CNT_WIDTH21-1:0]    slverr_cnt21,
  output logic [CNT_WIDTH21-1:0]    max_wait21
);

  apb_state_e                state_q;
  logic [NUM_SLAVES21-1:0]   cap_sel_q;
  logic [PADDR_WIDTH21-1:0]  cap_addr_q;
  logic                      cap_rwd_q;
  logic [PWDATA_WIDTH21-1:0] cap_wdata_q;
  logic [CNT_WIDTH21-1:0]    wait_cnt;
  logic [CNT_WIDTH21-1:0]    wait_final;

  logic psel_unk, psel_nz, pen_one, pen_zero, rdy_one, rwd_one, slverr_one;
  logic chg, setup_fail, is_access, idle_eval, go_setup;
  logic complete, waiting, timeout;
  logic [ERR_W-1:0] err_raw, err_new;

  // Decode of the current sample; unknown control values never count as asserted.
  always_comb begin
    psel_unk   = $isunknown(psel21);
    psel_nz    = !psel_unk && (psel21 != '0);
    pen_one    = !$isunknown(penable21) && penable21;
    pen_zero   = !$isunknown(penable21) && !penable21;
    rdy_one    = !$isunknown(pready21) && pready21;
    rwd_one    = !$isunknown(prwd21) && prwd21;
    slverr_one = !$isunknown(pslverr21) && pslverr21;

    chg = psel_unk || (psel21 != cap_sel_q)
       || $isunknown(paddr21) || (paddr21 != cap_addr_q)
       || $isunknown(prwd21) || (prwd21 != cap_rwd_q)
       || (cap_rwd_q && ($isunknown(pwdata21) || (pwdata21 != cap_wdata_q)))
       || !pen_one;

    setup_fail = (state_q == ST_SETUP) && chg;
    is_access  = (state_q == ST_ACCESS) || ((state_q == ST_SETUP) && !chg);
    idle_eval  = (state_q == ST_IDLE) || setup_fail;
    go_setup   = idle_eval && psel_nz && pen_zero;
    complete   = is_access && rdy_one;
    waiting    = is_access && !rdy_one;
    timeout    = waiting && ((32'(wait_cnt) + 32'd1) >= TIMEOUT_CYCLES21);

    // A timeout counts the cycle that expired as a wait state too.
    if (timeout && (wait_cnt != '1)) wait_final = wait_cnt + CNT_WIDTH21'(1);
    else                             wait_final = wait_cnt;

    err_raw               = '0;
    err_raw[ERR_PADDR]    = psel_nz && $isunknown(paddr21);
    err_raw[ERR_PRWD]     = psel_nz && $isunknown(prwd21);
    err_raw[ERR_PWDATA]   = psel_nz && rwd_one && $isunknown(pwdata21);
    err_raw[ERR_PENABLE]  = $isunknown(penable21);
    err_raw[ERR_PSEL]     = psel_unk;
    err_raw[ERR_PSLVERR]  = complete && $isunknown(pslverr21);
    err_raw[ERR_PRDATA]   = complete && !cap_rwd_q && $isunknown(prdata21);
    err_raw[ERR_MULTISEL] = psel_nz && ((psel21 & (psel21 - NUM_SLAVES21'(1))) != '0);
    err_raw[ERR_PROTOCOL] = (idle_eval && pen_one) || ((state_q != ST_IDLE) && chg);
    err_raw[ERR_TIMEOUT]  = timeout;

    err_new = has_checks21 ? err_raw : '0;
  end

  // Phase FSM, captured setup values and registered outputs.
  always_ff @(posedge pclock21) begin
    if (!preset21) begin
      state_q     <= ST_IDLE;
      cap_sel_q   <= '0;
      cap_addr_q  <= '0;
      cap_rwd_q   <= 1'b0;
      cap_wdata_q <= '0;
      err_vec21   <= '0;
      err_pulse21 <= 1'b0;
      xfer_done21 <= 1'b0;
      max_wait21  <= '0;
    end else begin
      err_pulse21 <= |err_new;
      err_vec21   <= err_clear21 ? err_new : (err_vec21 | err_new);
      xfer_done21 <= complete;
      if ((complete || timeout) && (wait_final > max_wait21)) max_wait21 <= wait_final;

      if (go_setup) begin
        cap_sel_q   <= psel21;
        cap_addr_q  <= paddr21;
        cap_rwd_q   <= prwd21;
        cap_wdata_q <= pwdata21;
      end

      unique case (state_q)
        ST_IDLE: state_q <= go_setup ? ST_SETUP : ST_IDLE;
        ST_SETUP, ST_ACCESS: begin
          if (go_setup)                 state_q <= ST_SETUP;
          else if (waiting && !timeout) state_q <= ST_ACCESS;
          else                          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  apb_sat_cnt21 #(.W(CNT_WIDTH21)) u_xfer_cnt (
    .clk   (pclock21),
    .rst_n (preset21),
    .clr   (1'b0),
    .inc   (complete),
    .cnt   (xfer_cnt21)
  );

  apb_sat_cnt21 #(.W(CNT_WIDTH21)) u_slverr_cnt (
    .clk   (pclock21),
    .rst_n (preset21),
    .clr   (1'b0),
    .inc   (complete && slverr_one),
    .cnt   (slverr_cnt21)
  );

  apb_sat_cnt21 #(.W(CNT_WIDTH21)) u_wait_cnt (
    .clk   (pclock21),
    .rst_n (preset21),
    .clr   (!waiting || timeout),
    .inc   (waiting),
    .cnt   (wait_cnt)
  );

endmodule

// File: tb/tb_apb_protocol_checker21.sv
// Bench for apb_protocol_checker21: directed scenarios plus randomized
// transfers, each cycle compared against a transaction-level expectation.
module tb_apb_protocol_checker21;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned NS   = 16;
  localparam int unsigned TMO  = 4;
  localparam int unsigned CW   = 4;
  localparam int unsigned CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          preset, has_checks, prwd, penable, pslverr, pready, err_clear;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata, prdata;
  logic [NS-1:0] psel;
  logic [9:0]    err_vec;
  logic          err_pulse, xfer_done;
  logic [CW-1:0] xfer_cnt, slverr_cnt, max_wait;

  // Expected state, derived from transaction outcomes.
  logic [9:0]  m_vec;
  logic        m_pulse, m_done;
  int unsigned m_cnt, m_slv, m_maxw;
  int          checks, passed;
  bit          rnd_clear;

  always #5 clk = ~clk;

  apb_protocol_checker21 #(
    .PADDR_WIDTH21(AW), .PWDATA_WIDTH21(DW), .PRDATA_WIDTH21(DW),
    .NUM_SLAVES21(NS), .TIMEOUT_CYCLES21(TMO), .CNT_WIDTH21(CW)
  ) dut (
    .pclock21(clk), .preset21(preset), .has_checks21(has_checks),
    .paddr21(paddr), .prwd21(prwd), .pwdata21(pwdata), .penable21(penable),
    .psel21(psel), .prdata21(prdata), .pslverr21(pslverr), .pready21(pready),
    .err_clear21(err_clear), .err_vec21(err_vec), .err_pulse21(err_pulse),
    .xfer_done21(xfer_done), .xfer_cnt21(xfer_cnt), .slverr_cnt21(slverr_cnt),
    .max_wait21(max_wait)
  );

  function automatic int unsigned sat(input int unsigned v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all();
    chk("err_vec",    32'(err_vec),    32'(m_vec));
    chk("err_pulse",  32'(err_pulse),  32'(m_pulse));
    chk("xfer_done",  32'(xfer_done),  32'(m_done));
    chk("xfer_cnt",   32'(xfer_cnt),   m_cnt);
    chk("slverr_cnt", 32'(slverr_cnt), m_slv);
    chk("max_wait",   32'(max_wait),   m_maxw);
  endtask

  // One bus cycle: the inputs already driven are sampled at the next edge.
  task automatic step(input logic [9:0] bits, input bit done, input bit tmo,
                      input int unsigned waits, input bit slv);
    logic [9:0] nb;
    @(posedge clk); #1;
    nb      = has_checks ? bits : 10'h000;
    m_vec   = err_clear ? nb : (m_vec | nb);
    m_pulse = |nb;
    m_done  = done;
    if (done) begin
      m_cnt = sat(m_cnt + 1);
      if (slv) m_slv = sat(m_slv + 1);
    end
    if ((done || tmo) && (waits > m_maxw)) m_maxw = waits;
    check_all();
    err_clear = rnd_clear && ($urandom_range(0, 7) == 0);
  endtask

  // Reset edge with the bus left as it is, then the bus returns to idle.
  task automatic do_reset();
    preset = 1'b0;
    @(posedge clk); #1;
    m_vec = '0; m_pulse = 1'b0; m_done = 1'b0; m_cnt = 0; m_slv = 0; m_maxw = 0;
    check_all();
    preset = 1'b1; psel = '0; penable = 1'b0; pready = 1'b0; pslverr = 1'b0;
  endtask

  task automatic idle(input int n);
    psel = '0; penable = 1'b0; pready = 1'b0; pslverr = 1'b0;
    repeat (n) step(10'h000, 1'b0, 1'b0, 0, 1'b0);
  endtask

  // Full transfer; glitch_at >= 1 flips paddr bit 2 in that access cycle only.
  task automatic xfer(input logic [NS-1:0] sel, input logic [AW-1:0] addr, input bit rw,
                      input logic [DW-1:0] wd, input int unsigned waits, input bit slv,
                      input int glitch_at);
    logic [9:0] multi;
    multi   = ($countones(sel) > 1) ? 10'h080 : 10'h000;
    psel    = sel; paddr = addr; prwd = rw; pwdata = wd;
    penable = 1'b0; pready = 1'b0; pslverr = 1'b0; prdata = DW'($urandom);
    step(multi, 1'b0, 1'b0, 0, 1'b0);
    penable = 1'b1;
    for (int i = 0; i < int'(waits); i++) begin
      paddr = (i == glitch_at) ? (addr ^ AW'(4)) : addr;
      step(multi | ((i == glitch_at) ? 10'h100 : 10'h000), 1'b0, 1'b0, 0, 1'b0);
    end
    paddr = addr; pready = 1'b1; pslverr = slv; prdata = DW'($urandom);
    step(multi, 1'b1, 1'b0, waits, slv);
    pready = 1'b0; pslverr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [NS-1:0] sel;
    int unsigned   w;
    int            g;
    checks = 0; passed = 0; rnd_clear = 1'b0;
    m_vec = '0; m_pulse = 1'b0; m_done = 1'b0; m_cnt = 0; m_slv = 0; m_maxw = 0;
    preset = 1'b0; has_checks = 1'b1; err_clear = 1'b0;
    paddr = '0; prwd = 1'b0; pwdata = '0; penable = 1'b0; psel = '0;
    prdata = '0; pslverr = 1'b0; pready = 1'b0;
    repeat (2) @(posedge clk);
    do_reset();

    // Zero-wait write, then read with two waits.
    xfer(16'h0001, 32'h10, 1'b1, 32'hA5A5_0001, 0, 1'b0, -1);
    xfer(16'h0001, 32'h10, 1'b0, 32'h0, 2, 1'b0, -1);
    idle(1);

    // Address moves in the second access cycle of a write.
    xfer(16'h0001, 32'h10, 1'b1, 32'hDEAD_BEEF, 2, 1'b0, 1);
    idle(1);

    // Two selects, then clear on a quiet bus.
    xfer(16'h0003, 32'h20, 1'b0, 32'h0, 0, 1'b0, -1);
    err_clear = 1'b1;
    idle(1);
    err_clear = 1'b0;

    // Clear coinciding with a fresh penable-without-select error: only bit 8 remains.
    xfer(16'h0003, 32'h24, 1'b1, 32'h1, 0, 1'b0, -1);
    psel = '0; penable = 1'b1; err_clear = 1'b1;
    step(10'h100, 1'b0, 1'b0, 0, 1'b0);
    err_clear = 1'b0;
    idle(1);

    // Randomized legal and faulty transfers with random masking and clears.
    rnd_clear = 1'b1;
    for (int n = 0; n < 60; n++) begin
      has_checks = ($urandom_range(0, 4) != 0);
      sel = NS'(1) << $urandom_range(0, NS - 1);
      if ($urandom_range(0, 5) == 0) sel = sel | (NS'(1) << $urandom_range(0, NS - 1));
      w = $urandom_range(0, 3);
      g = ((w >= 2) && ($urandom_range(0, 3) == 0)) ? int'($urandom_range(1, w - 1)) : -1;
      xfer(sel, AW'($urandom), 1'($urandom), DW'($urandom), w, 1'($urandom), g);
      if ($urandom_range(0, 1) == 1) idle(1);
    end
    rnd_clear = 1'b0; err_clear = 1'b0; has_checks = 1'b1;
    idle(1);
    err_clear = 1'b1;
    idle(1);
    err_clear = 1'b0;

    // Wait-state timeout, then a clean transfer is still counted.
    psel = 16'h0004; paddr = 32'h40; prwd = 1'b0; penable = 1'b0; pready = 1'b0;
    step(10'h000, 1'b0, 1'b0, 0, 1'b0);
    penable = 1'b1;
    repeat (TMO - 1) step(10'h000, 1'b0, 1'b0, 0, 1'b0);
    step(10'h200, 1'b0, 1'b1, TMO, 1'b0);
    idle(1);
    xfer(16'h0004, 32'h44, 1'b1, 32'h1234, 1, 1'b0, -1);
    idle(1);

    // Unknown address during a select, masked and then checked.
    for (int hc = 0; hc < 2; hc++) begin
      has_checks = 1'(hc);
      err_clear = 1'b1;
      psel = 16'h0001; paddr = 'x; penable = 1'b0;
      step($isunknown(paddr) ? 10'h001 : 10'h000, 1'b0, 1'b0, 0, 1'b0);
      err_clear = 1'b0;
      psel = '0; paddr = '0;
      step(10'h100, 1'b0, 1'b0, 0, 1'b0);
      idle(1);
    end

    // Read finishing with slave error and undriven data, then reset mid-access.
    do_reset();
    psel = 16'h0008; paddr = 32'h80; prwd = 1'b0; penable = 1'b0;
    step(10'h000, 1'b0, 1'b0, 0, 1'b0);
    penable = 1'b1; pready = 1'b1; pslverr = 1'b1; prdata = 'x;
    step($isunknown(prdata) ? 10'h040 : 10'h000, 1'b1, 1'b0, 0, 1'b1);
    pready = 1'b0; pslverr = 1'b0; prdata = '0;
    idle(1);
    psel = 16'h0008; paddr = 32'h84; penable = 1'b0;
    step(10'h000, 1'b0, 1'b0, 0, 1'b0);
    penable = 1'b1;
    step(10'h000, 1'b0, 1'b0, 0, 1'b0);
    do_reset();
    idle(2);
    xfer(16'h8000, 32'hFFFC, 1'b0, 32'h0, 3, 1'b0, -1);
    idle(1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
